// File: rtl/ray_frame_scheduler_pkg.sv
// Shared types and frame-size constants for the ray frame scheduler and its credit counter.
`ifndef PIXEL_X
`define PIXEL_X 639
`endif
`ifndef PIXEL_Y
`define PIXEL_Y 479
`endif

package ray_frame_scheduler_pkg;

  typedef struct packed {
    logic [15:0] posX;
    logic [15:0] posY;
    logic [15:0] posZ;
    logic [15:0] dirX;
    logic [15:0] dirY;
    logic [15:0] dirZ;
  } Camera;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} sched_state_t;

  localparam int NUM_PIXELS = (`PIXEL_X + 1) * (`PIXEL_Y + 1);

endpackage

// File: rtl/credit_counter.sv
// Tracks free slots in the downstream ray FIFO; a simultaneous consume and release cancel out,
// and a release with every slot already free is flagged and ignored.
module credit_counter #(
  parameter int CREDITS = 16,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          consume_i,
  input  logic          release_i,
  output logic [CW-1:0] count_o,
  output logic          available_o,
  output logic          overflow_o
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    if (consume_i && !release_i) begin
      count_d = count_q - CW'(1);
    end else if (release_i && !consume_i) begin
      if (count_q == FULL) begin
        overflow_o = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign available_o = (count_q != '0);

endmodule

// File: rtl/ray_frame_scheduler.sv
// Sequences one full frame of generator start pulses under FIFO credit flow control,
// counts returned rays and pulses frame_done_o once the last one is back.
`ifndef PIXEL_X
`define PIXEL_X 639
`endif
`ifndef PIXEL_Y
`define PIXEL_Y 479
`endif

module ray_frame_scheduler
  import ray_frame_scheduler_pkg::*;
#(
  parameter int PIXEL_X = `PIXEL_X,
  parameter int PIXEL_Y = `PIXEL_Y,
  parameter int CREDITS = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  frame_start_i,
  input  Camera cam_in_i,
  output Camera cam_out_o,
  output logic  gen_start_o,
  input  logic  gen_valid_i,
  input  logic  credit_return_i,
  output logic  busy_o,
  output logic  frame_done_o,
  output logic  error_o
);

  localparam int N     = (PIXEL_X + 1) * (PIXEL_Y + 1);
  localparam int CNT_W = $clog2(N + 1);
  localparam int CW    = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  returned_q, returned_d;
  Camera             cam_q, cam_d;
  logic              gen_start_q;
  logic              error_q, error_d;
  logic              issue;
  logic              count_valid;
  logic [CW-1:0]     credits;
  logic              credits_available;
  logic              credits_overflow;

  credit_counter #(.CREDITS(CREDITS)) u_credits (
    .clk        (clk),
    .reset      (reset),
    .consume_i  (issue),
    .release_i  (credit_return_i),
    .count_o    (credits),
    .available_o(credits_available),
    .overflow_o (credits_overflow)
  );

  // Issuing is already allowed in LOAD so the registered start lands in the first ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    cam_d       = cam_q;
    error_d     = error_q;
    issue       = (state_q == LOAD || state_q == ISSUE) && credits_available && (issued_q != LAST);
    count_valid = gen_valid_i && (state_q == ISSUE || state_q == DRAIN) && (returned_q != LAST);

    if (issue) issued_d = issued_q + CNT_W'(1);
    if (count_valid) returned_d = returned_q + CNT_W'(1);
    if (credits_overflow || (gen_valid_i && (state_q == IDLE || state_q == LOAD))) error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d    = LOAD;
          cam_d      = cam_in_i;
          issued_d   = '0;
          returned_d = '0;
        end
      end
      LOAD:    state_d = ISSUE;
      ISSUE:   if (issued_d == LAST) state_d = DRAIN;
      DRAIN:   if (returned_d == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      returned_q  <= '0;
      cam_q       <= '0;
      gen_start_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      cam_q       <= cam_d;
      gen_start_q <= issue;
      error_q     <= error_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) credits <= CW'(CREDITS));

  assign cam_out_o    = cam_q;
  assign gen_start_o  = gen_start_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == DONE);
  assign error_o      = error_q;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Self-checking bench for ray_frame_scheduler with an 8-pixel frame and 4 credits:
// a per-cycle reference model plus directed vectors with hand-computed timing.
module tb_ray_frame_scheduler;
  import ray_frame_scheduler_pkg::*;

  localparam int NPIX  = 8;
  localparam int NCRED = 4;
  localparam Camera CAM_A = Camera'(96'h0001_0002_0003_0004_0005_0006);
  localparam Camera CAM_B = Camera'(96'hA0A1_B0B1_C0C1_D0D1_E0E1_F0F1);
  localparam Camera CAM_C = Camera'(96'h1234_5678_9ABC_DEF0_0F0F_F0F0);

  logic  clk = 1'b0;
  logic  reset;
  logic  frameStart;
  Camera camIn;
  Camera camOut;
  logic  genStart;
  logic  genValid;
  logic  creditReturn;
  logic  busy;
  logic  frameDone;
  logic  errorFlag;

  ray_frame_scheduler #(.PIXEL_X(3), .PIXEL_Y(1), .CREDITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start_i  (frameStart),
    .cam_in_i       (camIn),
    .cam_out_o      (camOut),
    .gen_start_o    (genStart),
    .gen_valid_i    (genValid),
    .credit_return_i(creditReturn),
    .busy_o         (busy),
    .frame_done_o   (frameDone),
    .error_o        (errorFlag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit checkEn = 0;
  bit autoCredit = 0;
  bit forceValid = 0;
  bit forceCredit = 0;
  bit gsHist [0:6];
  int gsCount = 0, gsMark = 0, firstGsCyc = -1, lastGsCyc = -1;
  int doneCount = 0, doneCyc = -1, lastValidCyc = -1;
  int t, c;

  // Reference model: frame bookkeeping in plain integers
  bit    mActive = 0, mLoad = 0, mDone = 0, mErr = 0, mGs = 0;
  int    mIssued = 0, mReturned = 0, mCredits = NCRED, retOld;
  bit    issueNow;
  Camera mCam = '0;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit fs, input bit fv, input bit fc, input bit rst);
    frameStart  = fs;
    forceValid  = fv;
    forceCredit = fc;
    reset       = rst;
    tick(1);
    frameStart  = 1'b0;
    forceValid  = 1'b0;
    forceCredit = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int start;
    start = doneCount;
    for (int i = 0; i < limit && doneCount == start; i++) tick(1);
    checkOutput("frame_done within budget", 96'(doneCount != start), 96'(1));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model update: one step per clock edge, from the inputs seen during the cycle just ended
  initial forever begin
    @(posedge clk);
    if (reset) begin
      mActive = 0; mLoad = 0; mDone = 0; mErr = 0; mGs = 0;
      mIssued = 0; mReturned = 0; mCredits = NCRED; mCam = '0;
    end else begin
      issueNow = mActive && (mIssued < NPIX) && (mCredits > 0);
      retOld   = mReturned;
      if (genValid) begin
        if (!mActive || mLoad) mErr = 1;
        else if (mReturned < NPIX) mReturned++;
      end
      if (issueNow && !creditReturn) mCredits--;
      else if (creditReturn && !issueNow) begin
        if (mCredits == NCRED) mErr = 1;
        else mCredits++;
      end
      if (issueNow) mIssued++;
      mGs   = issueNow;
      mLoad = 0;
      if (mDone) begin
        mActive = 0;
        mDone   = 0;
      end else if (mActive) begin
        mDone = (retOld < NPIX) && (mReturned == NPIX);
      end else if (frameStart) begin
        mActive = 1; mLoad = 1; mCam = camIn; mIssued = 0; mReturned = 0;
      end
    end
  end

  // Generator echo, downstream FIFO pops, event log and per-cycle compare
  initial forever begin
    @(negedge clk);
    if (reset) begin
      for (int i = 0; i < 7; i++) gsHist[i] = 1'b0;
    end else begin
      for (int i = 6; i > 0; i--) gsHist[i] = gsHist[i-1];
      gsHist[0] = genStart;
    end
    genValid     = gsHist[5] || forceValid;
    creditReturn = (autoCredit && gsHist[1]) || forceCredit;
    if (genStart === 1'b1) begin
      if (gsCount == gsMark) firstGsCyc = cyc;
      gsCount++;
      lastGsCyc = cyc;
    end
    if (frameDone === 1'b1) begin
      doneCount++;
      doneCyc = cyc;
    end
    if (genValid) lastValidCyc = cyc;
    if (checkEn) begin
      checkOutput("gen_start", 96'(genStart), 96'(mGs));
      checkOutput("busy", 96'(busy), 96'(mActive));
      checkOutput("frame_done", 96'(frameDone), 96'(mDone));
      checkOutput("error", 96'(errorFlag), 96'(mErr));
      checkOutput("cam_out", camOut, mCam);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; frameStart = 1'b0; camIn = '0;
    genValid = 1'b0; creditReturn = 1'b0;
    @(posedge clk);
    #2;
    checkEn = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("reset busy", 96'(busy), 96'(0));
    checkOutput("reset gen_start", 96'(genStart), 96'(0));
    checkOutput("reset frame_done", 96'(frameDone), 96'(0));
    checkOutput("reset error", 96'(errorFlag), 96'(0));
    checkOutput("reset cam_out", camOut, 96'(0));

    $display("[TB] unthrottled frame");
    autoCredit = 1'b1;
    camIn = CAM_A;
    gsMark = gsCount;
    t = cyc;
    applyStimulus(1, 0, 0, 0);
    camIn = CAM_B;
    checkOutput("load busy", 96'(busy), 96'(1));
    checkOutput("cam latched at start", camOut, CAM_A);
    waitDone(40);
    checkOutput("frame issue count", 96'(gsCount - gsMark), 96'(NPIX));
    checkOutput("first gen_start cycle", 96'(firstGsCyc - t), 96'(2));
    checkOutput("last gen_start cycle", 96'(lastGsCyc - t), 96'(9));
    checkOutput("done after last valid", 96'(doneCyc - lastValidCyc), 96'(1));
    checkOutput("done cycle", 96'(doneCyc - t), 96'(15));
    checkOutput("busy after done", 96'(busy), 96'(0));

    $display("[TB] credit stall");
    autoCredit = 1'b0;
    gsMark = gsCount;
    t = cyc;
    applyStimulus(1, 0, 0, 0);
    tick(15);
    checkOutput("stall issue count", 96'(gsCount - gsMark), 96'(NCRED));
    checkOutput("stall last issue", 96'(lastGsCyc - t), 96'(5));
    checkOutput("stall busy", 96'(busy), 96'(1));
    c = cyc;
    applyStimulus(0, 0, 1, 0);
    tick(3);
    checkOutput("one credit one issue", 96'(gsCount - gsMark), 96'(NCRED + 1));
    checkOutput("released issue latency", 96'(lastGsCyc - c), 96'(2));
    forceCredit = 1'b1;
    tick(3);
    forceCredit = 1'b0;
    waitDone(40);
    checkOutput("stalled frame issue count", 96'(gsCount - gsMark), 96'(NPIX));
    forceCredit = 1'b1;
    tick(4);
    forceCredit = 1'b0;
    tick(1);
    checkOutput("credits refilled without error", 96'(errorFlag), 96'(0));

    $display("[TB] camera stability");
    autoCredit = 1'b1;
    camIn = CAM_B;
    gsMark = gsCount;
    c = doneCount;
    t = cyc;
    applyStimulus(1, 0, 0, 0);
    tick(3);
    camIn = CAM_C;
    applyStimulus(1, 0, 0, 0);
    checkOutput("cam held mid-frame", camOut, CAM_B);
    tick(10);
    applyStimulus(1, 0, 0, 0);
    checkOutput("start on done ignored", 96'(busy), 96'(0));
    checkOutput("single done pulse", 96'(doneCount - c), 96'(1));
    checkOutput("cam frame done cycle", 96'(doneCyc - t), 96'(15));
    checkOutput("cam frame issue count", 96'(gsCount - gsMark), 96'(NPIX));
    tick(3);
    checkOutput("still idle", 96'(busy), 96'(0));

    $display("[TB] errors");
    applyStimulus(0, 1, 0, 0);
    checkOutput("valid in idle error", 96'(errorFlag), 96'(1));
    tick(5);
    checkOutput("error sticky", 96'(errorFlag), 96'(1));
    applyStimulus(0, 0, 0, 1);
    checkOutput("error cleared by reset", 96'(errorFlag), 96'(0));
    applyStimulus(0, 0, 1, 0);
    checkOutput("credit overflow error", 96'(errorFlag), 96'(1));
    tick(3);
    checkOutput("overflow error sticky", 96'(errorFlag), 96'(1));
    applyStimulus(0, 0, 0, 1);
    checkOutput("error cleared again", 96'(errorFlag), 96'(0));

    $display("[TB] reset mid-frame");
    camIn = CAM_A;
    gsMark = gsCount;
    applyStimulus(1, 0, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("busy after mid-frame reset", 96'(busy), 96'(0));
    checkOutput("issues before reset", 96'(gsCount - gsMark), 96'(3));
    tick(2);
    checkOutput("no issue after reset", 96'(gsCount - gsMark), 96'(3));
    gsMark = gsCount;
    applyStimulus(1, 0, 0, 0);
    waitDone(40);
    checkOutput("recovered frame issue count", 96'(gsCount - gsMark), 96'(NPIX));
    checkOutput("recovered cam", camOut, CAM_A);
    checkOutput("recovered error", 96'(errorFlag), 96'(0));
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
